// File: rtl/fastica_matvec_if.sv
// Handshake and operand/result bus for the FastICA matrix-vector multiplier.
// The slave side is the multiplier. The master side is the whitening stage
// feeding operands and the downstream stage consuming results.
interface fastica_matvec_seq_if #(
  parameter int N  = 4,
  parameter int DW = 26
);
  logic              in_valid;
  logic              in_ready;
  logic [N*N*DW-1:0] w_flat;
  logic [N*DW-1:0]   z_flat;
  logic              out_valid;
  logic              out_ready;
  logic [N*DW-1:0]   y_flat;
  logic [N-1:0]      sat_flags;

  modport slave (
    input  in_valid, w_flat, z_flat, out_ready,
    output in_ready, out_valid, y_flat, sat_flags
  );

  modport master (
    output in_valid, w_flat, z_flat, out_ready,
    input  in_ready, out_valid, y_flat, sat_flags
  );
endinterface

// File: rtl/fastica_matvec_seq.sv
// Time-multiplexed fixed-point y = W*z for the FastICA datapath.
// There are N row MACs. Each one walks the columns, one column per cycle.
// The accumulated sums are then rounded half-up and rescaled by FRAC.
// Optional feature macro: FASTICA_MATVEC_SAT_EN. When it is defined, results
// are clamped to the DW range and flagged. Otherwise results wrap to DW bits.
module fastica_matvec_seq #(
  parameter int N    = 4,
  parameter int DW   = 26,
  parameter int FRAC = 16
) (
  input  logic                   clk_mul,
  input  logic                   rst_mul,
  fastica_matvec_seq_if.slave    bus
);
  localparam int ACC_W = 2*DW + $clog2(N);
  localparam int COL_W = (N > 1) ? $clog2(N) : 1;
  localparam logic signed [ACC_W-1:0] RND =
    (FRAC > 0) ? (ACC_W'(1) <<< (FRAC-1)) : '0;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_NORM, S_DONE} state_t;

  state_t                  r_state;
  logic [COL_W-1:0]        r_col;
  logic signed [DW-1:0]    r_w   [N][N];
  logic signed [DW-1:0]    r_z   [N];
  logic signed [ACC_W-1:0] r_acc [N];
  logic [N*DW-1:0]         r_y;
  logic                    r_out_valid;

  logic                    w_in_ready;
  logic                    w_accept;
  logic signed [ACC_W-1:0] w_prod [N];
  logic [DW-1:0]           w_fit  [N];
  logic [N-1:0]            w_clamp;

  // in_ready is decoded from state and reset only; there is no path from in_valid or out_ready.
  assign w_in_ready = (r_state == S_IDLE) && !rst_mul;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Row products for the current column. They are full precision, and the operands are sign-extended first.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      w_prod[r] = ACC_W'(r_w[r][r_col]) * ACC_W'(r_z[r_col]);
    end
  end

`ifdef FASTICA_MATVEC_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = (ACC_W'(1) <<< (DW-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] Y_MIN = -(ACC_W'(1) <<< (DW-1));
  logic [N-1:0] r_sat;

  // Round half-up, rescale, then clamp into the DW range and flag any clamping.
  always_comb begin
    logic signed [ACC_W-1:0] t;
    // NOTE: every output of a combinational block is given a default first, so no latch is inferred.
    w_clamp = '0;
    for (int r = 0; r < N; r++) begin
      t        = (r_acc[r] + RND) >>> FRAC;
      w_fit[r] = t[DW-1:0];
      if (t > Y_MAX) begin
        w_fit[r]   = Y_MAX[DW-1:0];
        w_clamp[r] = 1'b1;
      end else if (t < Y_MIN) begin
        w_fit[r]   = Y_MIN[DW-1:0];
        w_clamp[r] = 1'b1;
      end
    end
  end

  // Saturation flags are captured together with the result.
  always_ff @(posedge clk_mul or posedge rst_mul) begin
    if (rst_mul)                r_sat <= '0;
    else if (r_state == S_NORM) r_sat <= w_clamp;
  end

  assign bus.sat_flags = r_sat;
`else
  // Round half-up, rescale, then keep the low DW bits. This wraps on overflow.
  always_comb begin
    // NOTE: every output of a combinational block is given a default first, so no latch is inferred.
    w_clamp = '0;
    for (int r = 0; r < N; r++) begin
      w_fit[r] = DW'((r_acc[r] + RND) >>> FRAC);
    end
  end

  assign bus.sat_flags = w_clamp;
`endif

  // Operand capture on acceptance. Later changes on the inputs cannot disturb the running job.
  // NOTE: the operand store has no reset. It is always written before it is read, and leaving it out keeps it plain flops/RAM.
  always_ff @(posedge clk_mul) begin
    if (w_accept) begin
      for (int r = 0; r < N; r++) begin
        r_z[r] <= bus.z_flat[r*DW +: DW];
        for (int c = 0; c < N; c++) begin
          r_w[r][c] <= bus.w_flat[(r*N+c)*DW +: DW];
        end
      end
    end
  end

  // Control FSM and accumulators: accept, MAC over columns, normalise, then hold until consumed.
  // NOTE: all state here uses non-blocking assignments, so every update in a cycle sees the pre-edge values.
  always_ff @(posedge clk_mul or posedge rst_mul) begin
    if (rst_mul) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_y         <= '0;
      r_out_valid <= 1'b0;
      for (int r = 0; r < N; r++) r_acc[r] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_col   <= '0;
            r_state <= S_MAC;
            for (int r = 0; r < N; r++) r_acc[r] <= '0;
          end
        end
        S_MAC: begin
          for (int r = 0; r < N; r++) r_acc[r] <= r_acc[r] + w_prod[r];
          if (r_col == COL_W'(N-1)) begin
            r_col   <= '0;
            r_state <= S_NORM;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        S_NORM: begin
          for (int r = 0; r < N; r++) r_y[r*DW +: DW] <= w_fit[r];
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y_flat    = r_y;
endmodule

// File: tb/tb_fastica_matvec_seq.sv
// Directed self-checking bench for fastica_matvec_seq (N=4, DW=26, FRAC=16).
module tb_fastica_matvec_seq;
  localparam int N    = 4;
  localparam int DW   = 26;
  localparam int FRAC = 16;

  logic clk;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  fastica_matvec_seq_if #(.N(N), .DW(DW)) bus ();

  fastica_matvec_seq #(.N(N), .DW(DW), .FRAC(FRAC)) dut (
    .clk_mul (clk),
    .rst_mul (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity-style operands shared by several scenarios.
  logic [N*N*DW-1:0]    w_ident;
  logic [N*N*DW-1:0]    w_half;
  logic [N*DW-1:0]      z_ident;
  logic signed [DW-1:0] y_ident [N];
  logic signed [DW-1:0] y_half  [N];

  initial begin
    w_ident = '0;
    w_half  = '0;
    for (int i = 0; i < N; i++) begin
      w_ident[(i*N+i)*DW +: DW] = 26'sd65536;
      w_half[(i*N+i)*DW +: DW]  = 26'sd32768;
    end
    y_ident[0] = 26'sd65536;  y_ident[1] = 26'sd131072;
    y_ident[2] = -26'sd196608; y_ident[3] = 26'sd262144;
    y_half[0]  = 26'sd32768;  y_half[1]  = 26'sd65536;
    y_half[2]  = -26'sd98304;  y_half[3]  = 26'sd131072;
    for (int i = 0; i < N; i++) z_ident[i*DW +: DW] = y_ident[i];
  end

  // Present operands, wait for in_ready, and return the time of the accept edge. Afterwards the inputs are scrambled.
  task automatic start_job(input logic [N*N*DW-1:0] w, input logic [N*DW-1:0] z,
                           output time t_acc);
    int guard = 0;
    bus.w_flat   = w;
    bus.z_flat   = z;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready never rose within %0d cycles", guard);
    end
    @(posedge clk);
    t_acc = $time;
    #1;
    bus.in_valid = 1'b0;
    bus.w_flat   = ~w;
    bus.z_flat   = ~z;
  endtask

  // Count edges after acceptance until out_valid is seen. The wait is bounded.
  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.w_flat    = '0;
    bus.z_flat    = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.y_flat !== '0) $display("FAIL reset_y: got %h want 0", bus.y_flat); else n_pass++;
    n_total++; if (bus.sat_flags !== '0) $display("FAIL reset_sat: got %h want 0", bus.sat_flags); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_identity();
    time t; int cyc;
    bus.out_ready = 1'b1;
    start_job(w_ident, z_ident, t);
    wait_out(cyc);
    n_total++; if (cyc !== 5) $display("FAIL identity_latency: got %0d want 5", cyc); else n_pass++;
    for (int r = 0; r < N; r++) begin
      n_total++;
      if (bus.y_flat[r*DW +: DW] !== y_ident[r])
        $display("FAIL identity_y%0d: got %0d want %0d", r, $signed(bus.y_flat[r*DW +: DW]), y_ident[r]);
      else n_pass++;
    end
    n_total++; if (bus.sat_flags !== 4'h0) $display("FAIL identity_sat: got %h want 0", bus.sat_flags); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL identity_consume_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL identity_consume_ready: got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_rounding();
    logic [N*N*DW-1:0]    w;
    logic [N*DW-1:0]      z;
    logic signed [DW-1:0] zin [3];
    logic signed [DW-1:0] yexp [3];
    time t; int cyc;
    zin[0] = 26'sd32768;  yexp[0] = 26'sd1;
    zin[1] = -26'sd32768; yexp[1] = 26'sd0;
    zin[2] = -26'sd98304; yexp[2] = -26'sd1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      w = '0; w[0 +: DW] = 26'sd1;
      z = '0; z[0 +: DW] = zin[k];
      start_job(w, z, t);
      wait_out(cyc);
      n_total++;
      if (bus.y_flat[0 +: DW] !== yexp[k])
        $display("FAIL round_%0d_y0: got %0d want %0d", k, $signed(bus.y_flat[0 +: DW]), yexp[k]);
      else n_pass++;
      n_total++;
      if (bus.y_flat[N*DW-1:DW] !== '0)
        $display("FAIL round_%0d_rest: got %h want 0", k, bus.y_flat[N*DW-1:DW]);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_overflow();
    logic [N*N*DW-1:0]    w;
    logic [N*DW-1:0]      z;
    logic signed [DW-1:0] yexp;
    logic [N-1:0]         sexp;
    time t; int cyc;
    for (int i = 0; i < N*N; i++) w[i*DW +: DW] = 26'sd33554431;
    for (int i = 0; i < N; i++)   z[i*DW +: DW] = 26'sd33554431;
`ifdef FASTICA_MATVEC_SAT_EN
    yexp = 26'sd33554431; sexp = 4'hF;
`else
    // The sum is 2^52-2^28+4, and after rounding and the shift it becomes 2^36-4096. Its low 26 bits are -4096.
    yexp = -26'sd4096;    sexp = 4'h0;
`endif
    bus.out_ready = 1'b1;
    start_job(w, z, t);
    wait_out(cyc);
    for (int r = 0; r < N; r++) begin
      n_total++;
      if (bus.y_flat[r*DW +: DW] !== yexp)
        $display("FAIL overflow_y%0d: got %0d want %0d", r, $signed(bus.y_flat[r*DW +: DW]), yexp);
      else n_pass++;
    end
    n_total++; if (bus.sat_flags !== sexp) $display("FAIL overflow_sat: got %h want %h", bus.sat_flags, sexp); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    time t; int cyc; logic seen;
    bus.out_ready = 1'b0;
    start_job(w_ident, z_ident, t);
    wait_out(cyc);
    n_total++; if (cyc !== 5) $display("FAIL bp_latency: got %0d want 5", cyc); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        bus.w_flat = w_half; bus.z_flat = z_ident; bus.in_valid = 1'b1;
      end
      if (i == 4) bus.in_valid = 1'b0;
      @(posedge clk); #1;
      for (int r = 0; r < N; r++) begin
        n_total++;
        if (bus.y_flat[r*DW +: DW] !== y_ident[r])
          $display("FAIL bp_hold_y%0d_c%0d: got %0d want %0d", r, i, $signed(bus.y_flat[r*DW +: DW]), y_ident[r]);
        else n_pass++;
      end
      n_total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready_c%0d: got %b want 0", i, bus.in_ready); else n_pass++;
      n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid_c%0d: got %b want 1", i, bus.out_valid); else n_pass++;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); else n_pass++;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) seen = 1'b1;
    end
    n_total++; if (seen !== 1'b0) $display("FAIL bp_pulse_queued: got busy=%b want 0", seen); else n_pass++;
  endtask

  task automatic test_back_to_back();
    time t1, t2; int cyc;
    bus.out_ready = 1'b1;
    start_job(w_ident, z_ident, t1);
    wait_out(cyc);
    for (int r = 0; r < N; r++) begin
      n_total++;
      if (bus.y_flat[r*DW +: DW] !== y_ident[r])
        $display("FAIL b2b_job1_y%0d: got %0d want %0d", r, $signed(bus.y_flat[r*DW +: DW]), y_ident[r]);
      else n_pass++;
    end
    start_job(w_half, z_ident, t2);
    n_total++; if (t2 - t1 !== 70) $display("FAIL b2b_period: got %0t want 70 (7 cycles)", t2 - t1); else n_pass++;
    wait_out(cyc);
    n_total++; if (cyc !== 5) $display("FAIL b2b_latency: got %0d want 5", cyc); else n_pass++;
    for (int r = 0; r < N; r++) begin
      n_total++;
      if (bus.y_flat[r*DW +: DW] !== y_half[r])
        $display("FAIL b2b_job2_y%0d: got %0d want %0d", r, $signed(bus.y_flat[r*DW +: DW]), y_half[r]);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_job();
    time t; int cyc;
    bus.out_ready = 1'b1;
    start_job(w_ident, z_ident, t);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_total++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_total++; if (bus.y_flat !== '0) $display("FAIL midrst_y: got %h want 0", bus.y_flat); else n_pass++;
    n_total++; if (bus.in_ready !== 1'b0) $display("FAIL midrst_in_ready: got %b want 0", bus.in_ready); else n_pass++;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL midrst_after: got ready=%b valid=%b want 1/0", bus.in_ready, bus.out_valid); else n_pass++;
    start_job(w_ident, z_ident, t);
    wait_out(cyc);
    n_total++; if (cyc !== 5) $display("FAIL midrst_latency: got %0d want 5", cyc); else n_pass++;
    for (int r = 0; r < N; r++) begin
      n_total++;
      if (bus.y_flat[r*DW +: DW] !== y_ident[r])
        $display("FAIL midrst_y%0d: got %0d want %0d", r, $signed(bus.y_flat[r*DW +: DW]), y_ident[r]);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rounding();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fastica_matvec_seq.md
# fastica_matvec_seq

Parametrised, time-multiplexed fixed-point matrix-vector multiplier for the FastICA datapath. It computes y = W·z for an N×N weight matrix and an N-element whitened sample, with a valid/ready handshake on input and output. It uses N row MACs that iterate over columns, then applies rounding and a Q-format rescale. It is the generalised, handshaked successor to the fixed 4×4 single-cycle multiplier and sits between the whitening stage and the nonlinearity/update stage.

## Interface
- N, default 4: matrix dimension and channel count; must be ≥ 2.
- DW, default 26: signed two's-complement data width of W, z and y.
- FRAC, default 16: fractional bits (Q format); range 0..DW-1.
- ACC_W, a derived localparam equal to 2*DW + clog2(N): accumulator width; it never overflows.
- clk_mul, in, 1: the single clock; all logic is on the rising edge.
- rst_mul, in, 1: reset, asynchronous and active-high.
- in_valid, in, 1: w_flat and z_flat are valid.
- in_ready, out, 1: block accepts an operand set; equals (state==IDLE) && !rst_mul.
- w_flat, in, N*N*DW: element (r,c) is at [(r*N+c)*DW +: DW].
- z_flat, in, N*DW: element c is at [c*DW +: DW].
- out_valid, out, 1: y_flat and sat_flags are valid.
- out_ready, in, 1: consumer accepts the result.
- y_flat, out, N*DW: element r is at [r*DW +: DW].
- sat_flags, out, N: bit r is set when y[r] was clamped.

## Operation
- The FSM has four states: IDLE, MAC, NORM and DONE.
- **IDLE:** on in_valid && in_ready, latch w_flat and z_flat into internal registers, clear all N accumulators, set col=0, and go to MAC. Input changes after acceptance have no effect.
- **MAC:** each cycle, acc[r] += wreg[r][col] * zreg[col] for all r in parallel, as a full-precision signed product sign-extended to ACC_W. col increments each cycle. When col==N-1, go to NORM.
- **NORM:** for each r, t = (acc[r] + (FRAC>0 ? 2^(FRAC-1) : 0)) >>> FRAC. This is arithmetic shift with round-half-up toward +inf. Then y[r] = fit(t) per Configuration. Register y_flat and sat_flags, and go to DONE.
- **DONE:** out_valid=1. y_flat and sat_flags stay stable until out_ready is sampled high. On that edge, go to IDLE with out_valid=0.
- Results are held indefinitely under backpressure. in_ready stays 0 from acceptance until the cycle after the output is consumed, so there is no overlap of jobs.
- Reset values: state=IDLE, col=0, all acc=0, y_flat=0, sat_flags=0, out_valid=0. in_ready is 0 while rst_mul is high and 1 on the first cycle after release.
- Reset asserted mid-MAC, NORM or DONE aborts the job immediately. No partial result is ever presented.
- in_valid while busy is ignored and not queued. The source holds it until in_ready.

## Timing
- Acceptance edge is k.
- MAC occupies edges k+1..k+N.
- NORM registers the result at edge k+N+1, and out_valid is high from that edge.
- Latency from accept to out_valid is N+1 cycles; for N=4 that is 5.
- If out_ready is already high, consumption occurs at edge k+N+2. in_ready returns high after that edge.
- Minimum job period is N+3 cycles.
- All outputs are registered except in_ready, which is decoded from state only and has no combinational path from in_valid or out_ready.

## Configuration
- Macro: FASTICA_MATVEC_SAT_EN.
- **Defined:** fit(t) clamps to [-2^(DW-1), 2^(DW-1)-1]. sat_flags[r]=1 when clamping occurred.
- **Undefined:** fit(t) = t[DW-1:0], i.e. wrap/truncation. sat_flags is tied to 0 and the clamp logic is removed.

## Test plan
Bench parameters: N=4, DW=26, FRAC=16 (1.0 = 65536).
- **Identity:** W=I (diagonal 65536), z=(65536, 131072, -196608, 262144) → y=z, sat_flags=0, out_valid exactly 5 cycles after the accept edge.
- **Rounding:** W[0][0]=1, z[0]=32768, all else 0 → y[0]=1. With z[0]=-32768, y[0]=0. With z[0]=-98304, y[0]=-1.
- **Overflow:** all W and z equal 2^25-1. With the macro defined, y[r]=33554431 and sat_flags=4'hF. With the macro undefined, y equals the low 26 bits of the rounded, shifted sum, and sat_flags=0.
- **Backpressure:** hold out_ready=0 for 10 cycles after out_valid. y_flat must be stable and in_ready=0 throughout. An in_valid pulse during this window is not accepted. Then raise out_ready for 1 cycle → out_valid=0 and in_ready=1 next cycle.
- **Reset mid-job:** assert rst_mul asynchronously 2 cycles into MAC → out_valid and y_flat go to 0 immediately. After release, a new identity job completes correctly with no residue.
- **Back-to-back:** two jobs with out_ready tied to 1 → second accept occurs 7 cycles after the first, and both results are correct.
